// File: rtl/matrix_pkg.sv
// Shared types, defaults and arithmetic helpers for the matrix-vector multiplier.
package matrix_pkg;

    typedef enum logic [1:0] {StIdle, StAcc, StFin} state_e;

    localparam int unsigned DefW    = 32;
    localparam int unsigned DefFrac = 16;

    // Helpers operate on a fixed maximum width so one function serves every instance.
    localparam int unsigned MaxW    = 64;
    localparam int unsigned MaxAccW = 2 * MaxW + 3;

    typedef struct packed {
        logic            ovf;
        logic [MaxW-1:0] value;
    } sat_t;

    // Product is 2W bits; summing N of them needs clog2(N) extra bits of headroom.
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned w);
        return 2 * w + $clog2(n);
    endfunction

    // Reduce a shifted accumulator to w bits, either clamping or keeping the low bits.
    function automatic sat_t sat_wrap(input logic signed [MaxAccW-1:0] val,
                                      input int unsigned w, input bit sat);
        logic signed [MaxAccW-1:0] hi;
        logic signed [MaxAccW-1:0] lo;
        sat_t r;
        hi = '0;
        hi[w-1] = 1'b1;
        hi = hi - MaxAccW'(1);
        lo = ~hi;
        r.ovf   = (val > hi) || (val < lo);
        r.value = val[MaxW-1:0];
        if (sat && r.ovf) begin
            r.value = (val < lo) ? lo[MaxW-1:0] : hi[MaxW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_vec_mac_lane.sv
// One row lane: accumulates mat[r][idx]*vec[idx] and presents the scaled, reduced result.
module matrix_vec_mac_lane
    import matrix_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = DefW,
    parameter int unsigned FRAC = DefFrac,
    parameter bit          SAT  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] mat_elem,
    input  logic [W-1:0] vec_elem,
    output logic [W-1:0] result,
    output logic         ovf
);

    localparam int unsigned AccW = acc_width(N, W);

    logic signed [2*W-1:0]  prod;
    logic signed [AccW-1:0] acc_q;
    logic signed [AccW-1:0] shifted;
    sat_t                   sw;

    // Full-precision signed product of the current row and vector elements.
    always_comb begin
        prod = (2*W)'($signed(mat_elem)) * (2*W)'($signed(vec_elem));
    end

    // Accumulator: cleared on vector acceptance, one MAC per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= acc_q + AccW'(prod);
        end
    end

    // Drop fractional bits (floor) and fit the value back into W bits.
    always_comb begin
        shifted = acc_q >>> FRAC;
        sw      = sat_wrap(MaxAccW'(shifted), W, SAT);
        result  = sw.value[W-1:0];
        ovf     = sw.ovf;
    end

endmodule

// File: rtl/matrix_vec_mult_pipe.sv
// Fixed-point N x N matrix times N-vector, one MAC lane per row, valid/ready in and out.
module matrix_vec_mult_pipe
    import matrix_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = DefW,
    parameter int unsigned FRAC = DefFrac,
    parameter bit          SAT  = 1'b1
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      mat_load_in,
    input  logic [N-1:0][N-1:0][W-1:0] mat_in,
    input  logic                      vec_valid_in,
    input  logic [N-1:0][W-1:0]       vec_in,
    output logic                      vec_ready_out,
    output logic                      res_valid_out,
    input  logic                      res_ready_in,
    output logic [N-1:0][W-1:0]       res_out,
    output logic                      ovf_out,
    output logic                      busy_out
);

    localparam int unsigned IdxW = $clog2(N);

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q;
    logic [N-1:0][N-1:0][W-1:0] mat_q;
    logic [N-1:0][W-1:0]       vec_q;
    logic [N-1:0][W-1:0]       res_q;
    logic                      res_valid_q;
    logic                      ovf_q;
    logic [N-1:0][W-1:0]       lane_res;
    logic [N-1:0]              lane_ovf;
    logic                      accept;
    logic                      enable;
    logic                      load;

    // Next state and handshake decode; a matrix load blocks vector acceptance.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        enable        = 1'b0;
        load          = 1'b0;
        vec_ready_out = (state_q == StIdle) && !mat_load_in;
        unique case (state_q)
            StIdle: begin
                accept = vec_valid_in && vec_ready_out;
                if (accept) state_d = StAcc;
            end
            StAcc: begin
                enable = 1'b1;
                if (idx_q == IdxW'(N - 1)) state_d = StFin;
            end
            StFin: begin
                // Output slot is free, or is being drained this very cycle.
                load = !res_valid_q || res_ready_in;
                if (load) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and column index registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q <= '0;
            end else if (enable) begin
                idx_q <= (idx_q == IdxW'(N - 1)) ? '0 : idx_q + IdxW'(1);
            end
        end
    end

    // Matrix is only writable while idle so a computation never sees it change.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mat_q <= '0;
            vec_q <= '0;
        end else begin
            if ((state_q == StIdle) && mat_load_in) mat_q <= mat_in;
            if (accept) vec_q <= vec_in;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_lane
        matrix_vec_mac_lane #(
            .N    (N),
            .W    (W),
            .FRAC (FRAC),
            .SAT  (SAT)
        ) u_lane (
            .clk      (clk_in),
            .rst_n    (rst_n_in),
            .clear    (accept),
            .enable   (enable),
            .mat_elem (mat_q[r][idx_q]),
            .vec_elem (vec_q[idx_q]),
            .result   (lane_res[r]),
            .ovf      (lane_ovf[r])
        );
    end

    // Single-entry output register; held stable while the consumer stalls.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            res_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else if (load) begin
            res_q       <= lane_res;
            ovf_q       <= |lane_ovf;
            res_valid_q <= 1'b1;
        end else if (res_valid_q && res_ready_in) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_out       = res_q;
    assign ovf_out       = ovf_q;
    assign res_valid_out = res_valid_q;
    assign busy_out      = (state_q != StIdle);

endmodule
